// File: rtl/dmem_wb_bridge_pkg.sv
// Shared types for the data-memory to Wishbone bridge.
//   wb_state_e : bridge FSM states (IDLE, BUS, WAIT, DONE)
//   wb_req_t   : registered copy of one core access as presented on the bus
//   word_align : clears the byte offset of a byte address
package dmem_wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } wb_req_t;

    localparam logic [3:0] SEL_ALL = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dmem_wb_bridge.sv
// Bridges the core's MEM-stage data port onto a pipelined Wishbone B4 master.
// Every core access becomes one single-beat bus cycle; the pipeline is held
// until the slave acks, errors, or the bridge gives up after TIMEOUT_CYCLES.
//
// Ports
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   dmem_addr_i            core byte address
//   dmem_read_i            load request
//   dmem_wsel_byte_i       store byte enables (nonzero = store; store beats load)
//   dmem_wdata_i           store data
//   dmem_rdata_o           load data, meaningful only in the DONE cycle
//   dmem_stall_o           hold MEM and upstream stages
//   dmem_err_o             one-cycle error pulse in the DONE cycle
//   wb_cyc_o .. wb_dat_o   Wishbone master request side
//   wb_dat_i .. wb_stall_i Wishbone master response side
//
// Handshake: in BUS the strobe is accepted on the first cycle wb_stall_i=0;
// in WAIT the first of wb_err_i / wb_ack_i / timeout ends the cycle, with
// err taking precedence over ack. Core inputs are sampled only in IDLE.
module dmem_wb_bridge
    import dmem_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_read_i,
    input  logic [3:0]  dmem_wsel_byte_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_stall_o,
    output logic        dmem_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam int CNT_NEED = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e         state_q, state_d;
    wb_req_t           req_q, req_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic is_store;
    logic req;
    logic stall_c;
    logic bus_active;

    assign is_store = |dmem_wsel_byte_i;
    assign req      = dmem_read_i | is_store;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        stall_c      = 1'b0;
        bus_active   = 1'b0;
        wb_cyc_o     = 1'b0;
        wb_stb_o     = 1'b0;
        dmem_rdata_o = '0;
        dmem_err_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall_c     = 1'b1;
                    req_d.adr   = word_align(dmem_addr_i);
                    req_d.sel   = is_store ? dmem_wsel_byte_i : SEL_ALL;
                    req_d.dat   = dmem_wdata_i;
                    req_d.we    = is_store;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                stall_c    = 1'b1;
                bus_active = 1'b1;
                wb_cyc_o   = 1'b1;
                wb_stb_o   = 1'b1;
                if (!wb_stall_i) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_c    = 1'b1;
                bus_active = 1'b1;
                wb_cyc_o   = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (wb_err_i || (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else if (wb_ack_i) begin
                    // A store's ack carries no load data for the core.
                    rdata_d = req_q.we ? 32'h0 : wb_dat_i;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The core still presents the finished access here, so req
                // is not looked at until the following IDLE cycle.
                dmem_rdata_o = rdata_q;
                dmem_err_o   = err_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The core may still drive a request while reset is held; stall must
    // stay low then, so the IDLE request path is qualified by reset.
    assign dmem_stall_o = stall_c & rstn_i;

    // Request fields are shown only while a bus cycle is open.
    assign wb_we_o  = bus_active & req_q.we;
    assign wb_adr_o = bus_active ? req_q.adr : 32'h0;
    assign wb_sel_o = bus_active ? req_q.sel : 4'h0;
    assign wb_dat_o = bus_active ? req_q.dat : 32'h0;

endmodule

// File: tb/tb_dmem_wb_bridge.sv
module tb_dmem_wb_bridge;

    localparam int TO = 4;

    logic        clk_i;
    logic        rstn_i;
    logic [31:0] dmem_addr_i;
    logic        dmem_read_i;
    logic [3:0]  dmem_wsel_byte_i;
    logic [31:0] dmem_wdata_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_stall_o;
    logic        dmem_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    dmem_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .dmem_addr_i      (dmem_addr_i),
        .dmem_read_i      (dmem_read_i),
        .dmem_wsel_byte_i (dmem_wsel_byte_i),
        .dmem_wdata_i     (dmem_wdata_i),
        .dmem_rdata_o     (dmem_rdata_o),
        .dmem_stall_o     (dmem_stall_o),
        .dmem_err_o       (dmem_err_o),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_we_o          (wb_we_o),
        .wb_adr_o         (wb_adr_o),
        .wb_sel_o         (wb_sel_o),
        .wb_dat_o         (wb_dat_o),
        .wb_dat_i         (wb_dat_i),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i),
        .wb_stall_i       (wb_stall_i)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle output vector:
    // {stall, err, cyc, stb, we, sel[3:0], adr[31:0], dat[31:0], rdata[31:0]}
    logic [104:0] exp_q[$];

    function automatic logic [104:0] mk(input logic stall, input logic err,
                                        input logic cyc, input logic stb,
                                        input logic we, input logic [3:0] sel,
                                        input logic [31:0] adr, input logic [31:0] dat,
                                        input logic [31:0] rdata);
        return {stall, err, cyc, stb, we, sel, adr, dat, rdata};
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk_i) begin
        logic [104:0] e;
        logic [104:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dmem_stall_o, dmem_err_o, wb_cyc_o, wb_stb_o, wb_we_o,
                 wb_sel_o, wb_adr_o, wb_dat_o, dmem_rdata_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    // ---------------- transaction monitor (feeds literal checks) ----------------
    int          run_cnt = 0;
    int          last_run = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] rec_adr = '0;
    logic [3:0]  rec_sel = '0;
    logic        rec_we = 1'b0;

    always @(negedge clk_i) begin
        if (!rstn_i) begin
            run_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (wb_stb_o) begin
                rec_adr = wb_adr_o;
                rec_sel = wb_sel_o;
                rec_we  = wb_we_o;
            end
            if (dmem_stall_o) begin
                run_cnt++;
            end else if (prev_stall) begin
                last_run   = run_cnt;
                last_rdata = dmem_rdata_o;
                last_err   = dmem_err_o;
                run_cnt    = 0;
            end
            prev_stall = dmem_stall_o;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycle(input logic ack, input logic err);
        @(posedge clk_i); #1;
        dmem_read_i      = 1'b0;
        dmem_wsel_byte_i = 4'h0;
        wb_ack_i         = ack;
        wb_err_i         = err;
        wb_stall_i       = 1'b0;
        wb_dat_i         = $urandom;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0));
    endtask

    // One core access. n_stall = BUS cycles with wb_stall_i high; resp_j = WAIT
    // cycle index carrying the response (-1 = none, forcing the timeout).
    task automatic run_txn(input logic [31:0] addr, input logic rd,
                           input logic [3:0] wsel, input logic [31:0] wdata,
                           input int n_stall, input bit bus_noise,
                           input int resp_j, input bit do_ack, input bit do_err,
                           input logic [31:0] rdat);
        logic        st;
        logic [31:0] ea;
        logic [3:0]  es;
        bit          done_f;
        bit          e_err;
        logic [31:0] e_rd;
        int          j;
        st = |wsel;
        ea = addr & 32'hFFFF_FFFC;
        es = st ? wsel : 4'hF;
        // IDLE cycle carrying the new request
        @(posedge clk_i); #1;
        dmem_addr_i      = addr;
        dmem_read_i      = rd;
        dmem_wsel_byte_i = wsel;
        dmem_wdata_i     = wdata;
        wb_ack_i         = 1'b0;
        wb_err_i         = 1'b0;
        wb_stall_i       = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0));
        // strobe phase
        for (int i = 0; i <= n_stall; i++) begin
            @(posedge clk_i); #1;
            wb_stall_i = (i < n_stall);
            wb_ack_i   = bus_noise;
            wb_err_i   = bus_noise;
            wb_dat_i   = $urandom;
            exp_q.push_back(mk(1, 0, 1, 1, st, es, ea, wdata, 32'h0));
        end
        // waiting for the slave
        done_f = 1'b0;
        e_err  = 1'b0;
        e_rd   = 32'h0;
        j      = 0;
        while (!done_f) begin
            @(posedge clk_i); #1;
            wb_stall_i = 1'($urandom_range(0, 1));
            if (j == resp_j) begin
                wb_ack_i = do_ack;
                wb_err_i = do_err;
                wb_dat_i = rdat;
                done_f   = 1'b1;
                e_err    = do_err;
                e_rd     = do_err ? 32'h0 : (st ? 32'h0 : rdat);
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
            if (j == TO - 1 && !done_f) begin
                done_f = 1'b1;
                e_err  = 1'b1;
                e_rd   = 32'h0;
            end
            exp_q.push_back(mk(1, 0, 1, 0, st, es, ea, wdata, 32'h0));
            j++;
        end
        // completion cycle, core still shows the access
        @(posedge clk_i); #1;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i   = $urandom;
        exp_q.push_back(mk(0, e_err, 0, 0, 0, 4'h0, 32'h0, 32'h0, e_rd));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn_i           = 1'b1;
        dmem_addr_i      = '0;
        dmem_read_i      = 1'b0;
        dmem_wsel_byte_i = '0;
        dmem_wdata_i     = '0;
        wb_dat_i         = '0;
        wb_ack_i         = 1'b0;
        wb_err_i         = 1'b0;
        wb_stall_i       = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        check("reset_cyc",   32'(wb_cyc_o),     32'h0);
        check("reset_stb",   32'(wb_stb_o),     32'h0);
        check("reset_stall", 32'(dmem_stall_o), 32'h0);
        check("reset_err",   32'(dmem_err_o),   32'h0);
        check("reset_rdata", dmem_rdata_o,      32'h0);
        check("reset_adr",   wb_adr_o,          32'h0);
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        idle_cycle(0, 0);

        // load, ack right after strobe acceptance
        run_txn(32'h0000_2000, 1, 4'h0, 32'h0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        idle_cycle(0, 0);
        check("load_stall_cycles", 32'(last_run), 32'd3);
        check("load_rdata",        last_rdata,    32'hDEADBEEF);
        check("load_err",          32'(last_err), 32'h0);
        check("load_sel",          32'(rec_sel),  32'hF);

        // byte store to an unaligned address
        run_txn(32'h0000_1003, 0, 4'b1000, 32'hAABB_CCDD, 0, 0, 0, 1, 0, 32'h0);
        idle_cycle(0, 0);
        check("sb_adr",   rec_adr,          32'h0000_1000);
        check("sb_sel",   32'(rec_sel),     32'h8);
        check("sb_we",    32'(rec_we),      32'h1);
        check("sb_rdata", last_rdata,       32'h0);

        // slave stalls the strobe for 5 cycles, stray ack/err meanwhile
        run_txn(32'h0000_3004, 0, 4'hF, 32'h1234_5678, 5, 1, 1, 1, 0, 32'h0);
        idle_cycle(0, 0);
        check("stall_cycles", 32'(last_run), 32'd9);

        // no response: timeout, then a late ack and err in IDLE
        run_txn(32'h0000_4000, 1, 4'h0, 32'h0, 0, 0, -1, 0, 0, 32'h0);
        idle_cycle(1, 0);
        idle_cycle(0, 1);
        check("timeout_stall_cycles", 32'(last_run), 32'd6);
        check("timeout_err",          32'(last_err), 32'h1);

        // ack and err together
        run_txn(32'h0000_4010, 1, 4'h0, 32'h0, 0, 0, 1, 1, 1, 32'h5555_AAAA);
        idle_cycle(0, 0);
        check("ackerr_err",   32'(last_err), 32'h1);
        check("ackerr_rdata", last_rdata,    32'h0);

        // load and store both requested: store wins
        run_txn(32'h0000_5006, 1, 4'b0011, 32'h0BAD_F00D, 1, 0, 0, 1, 0, 32'h0);
        idle_cycle(0, 0);
        check("both_we",  32'(rec_we),  32'h1);
        check("both_sel", 32'(rec_sel), 32'h3);
        check("both_adr", rec_adr,      32'h0000_5004);

        // plain bus error on a load
        run_txn(32'h0000_6000, 1, 4'h0, 32'h0, 0, 0, 2, 0, 1, 32'h0);
        idle_cycle(0, 0);

        // back-to-back loads
        run_txn(32'h0000_6100, 1, 4'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0102_0304);
        run_txn(32'h0000_6104, 1, 4'h0, 32'h0, 2, 0, 1, 1, 0, 32'hA5A5_5A5A);
        idle_cycle(0, 0);

        // reset asserted while waiting for the slave
        @(posedge clk_i); #1;
        dmem_addr_i      = 32'h0000_7000;
        dmem_read_i      = 1'b1;
        dmem_wsel_byte_i = 4'h0;
        wb_stall_i       = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0));
        @(posedge clk_i); #1;
        exp_q.push_back(mk(1, 0, 1, 1, 0, 4'hF, 32'h0000_7000, 32'h0, 32'h0));
        @(posedge clk_i); #1;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 4'hF, 32'h0000_7000, 32'h0, 32'h0));
        @(negedge clk_i); #2;
        rstn_i = 1'b0;
        #1;
        check("rst_mid_cyc",   32'(wb_cyc_o),     32'h0);
        check("rst_mid_stb",   32'(wb_stb_o),     32'h0);
        check("rst_mid_stall", 32'(dmem_stall_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_hold_cyc", 32'(wb_cyc_o), 32'h0);
        rstn_i      = 1'b1;
        dmem_read_i = 1'b0;
        idle_cycle(0, 0);
        run_txn(32'h0000_6008, 1, 4'h0, 32'h0, 0, 0, 0, 1, 0, 32'hCAFE_F00D);
        idle_cycle(0, 0);
        check("post_rst_stall_cycles", 32'(last_run), 32'd3);
        check("post_rst_rdata",        last_rdata,    32'hCAFE_F00D);

        idle_cycle(0, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
